// File: rtl/div_sequencer.sv
// Front-end for the multi-cycle divider: buffers tagged operand pairs in an
// in-order FIFO, issues them one at a time, and returns tagged quotients.
module div_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             div_start,
  output logic [15:0]      div_a,
  output logic [15:0]      div_b,
  input  logic [15:0]      div_result,
  input  logic             div_overflow,
  input  logic             div_finish,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_result,
  output logic             out_overflow,
  output logic             out_timeout,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  typedef struct packed {
    logic [15:0]      a;
    logic [15:0]      b;
    logic [TAG_W-1:0] tag;
  } req_t;

  req_t             mem_q [FIFO_DEPTH];
  req_t             head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_t           state_q, state_d;
  logic [15:0]      div_a_q, div_a_d, div_b_q, div_b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic [15:0]      res_q, res_d;
  logic             ovf_q, ovf_d, tmo_q, tmo_d;
  logic             push, pop;

  assign in_ready = (count_q != CNT_W'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  assign head     = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{a: in_a, b: in_b, tag: in_tag};
    end
  end

  always_comb begin
    state_d  = state_q;
    div_a_d  = div_a_q;
    div_b_d  = div_b_q;
    tag_d    = tag_q;
    wdog_d   = wdog_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    tmo_d    = tmo_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop   = 1'b1;
          tag_d = head.tag;
          if (head.b != '0) begin
            div_a_d = head.a;
            div_b_d = head.b;
            wdog_d  = '0;
            state_d = ISSUE;
          end else begin
            // Divide-by-zero saturates by dividend sign; divider is bypassed.
            res_d   = head.a[15] ? 16'h8000 : 16'h7FFF;
            ovf_d   = 1'b1;
            tmo_d   = 1'b0;
            state_d = HOLD;
          end
        end
      end
      ISSUE: begin
        wdog_d = wdog_q + WD_W'(1);
        if (div_finish) begin
          res_d   = div_result;
          ovf_d   = div_overflow;
          tmo_d   = 1'b0;
          state_d = HOLD;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          res_d   = '0;
          ovf_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      div_a_q  <= '0;
      div_b_q  <= '0;
      tag_q    <= '0;
      wdog_q   <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      div_a_q  <= div_a_d;
      div_b_q  <= div_b_d;
      tag_q    <= tag_d;
      wdog_q   <= wdog_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      tmo_q    <= tmo_d;
    end
  end

  assign div_start    = (state_q == ISSUE);
  assign out_valid    = (state_q == HOLD);
  assign div_a        = div_a_q;
  assign div_b        = div_b_q;
  assign out_result   = res_q;
  assign out_overflow = ovf_q;
  assign out_timeout  = tmo_q;
  assign out_tag      = tag_q;
  assign busy         = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a fixed-latency divider model.
module tb_div_sequencer;

  localparam int L = 23;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [15:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic        div_start;
  logic [15:0] div_a, div_b, div_result;
  logic        div_overflow, div_finish;
  logic        out_valid, out_ready;
  logic [15:0] out_result;
  logic        out_overflow, out_timeout;
  logic [3:0]  out_tag;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_sequencer #(.FIFO_DEPTH(4), .TAG_W(4), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_result(div_result), .div_overflow(div_overflow), .div_finish(div_finish),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow), .out_timeout(out_timeout),
    .out_tag(out_tag), .busy(busy)
  );

  // Divider model: unsigned quotient, overflow flags a set dividend MSB.
  logic [7:0] mcnt;
  logic       hang;
  always @(posedge clk) mcnt <= div_start ? mcnt + 8'd1 : 8'd0;
  assign div_finish   = div_start && !hang && (mcnt == 8'(L - 1));
  assign div_result   = (div_b != 16'd0) ? div_a / div_b : 16'd0;
  assign div_overflow = div_a[15];

  typedef struct {
    logic [15:0] r;
    logic        o;
    logic        t;
    logic [3:0]  g;
  } res_t;

  res_t got_q[$];
  int   starts = 0, run = 0, last_run = 0, gap = 0, min_gap = 1000;
  logic prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (div_start && !prev) begin
        starts++;
        if (starts > 1 && gap < min_gap) min_gap = gap;
        run = 1;
      end else if (div_start) begin
        run++;
      end else if (prev) begin
        last_run = run;
        gap = 1;
      end else begin
        gap++;
      end
      prev = div_start;
      if (out_valid && out_ready)
        got_q.push_back('{r: out_result, o: out_overflow, t: out_timeout, g: out_tag});
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = t;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic push_lat(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t,
                          output int lat);
    push(a, b, t);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_results(input int cnt);
    int n = 0;
    while (got_q.size() < cnt && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("result_count", got_q.size(), cnt);
  endtask

  task automatic check_res(input string tag, input int idx, input logic [15:0] r,
                           input logic o, input logic [3:0] g);
    if (idx < got_q.size()) begin
      check({tag, "_res"}, got_q[idx].r, r);
      check({tag, "_ovf"}, got_q[idx].o, o);
      check({tag, "_tmo"}, got_q[idx].t, 0);
      check({tag, "_tag"}, got_q[idx].g, g);
    end else begin
      check({tag, "_missing"}, 0, 1);
    end
  endtask

  logic [15:0] exp_r [6] = '{16'd14, 16'h0123, 16'h0101, 16'h0000, 16'h7FFF, 16'h0001};
  logic        exp_o [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [15:0] va    [6] = '{16'd100, 16'h1234, 16'hFFFF, 16'h0005, 16'h7FFF, 16'h8000};
  logic [15:0] vb    [6] = '{16'd7, 16'h0010, 16'h00FF, 16'h0009, 16'h0001, 16'h8000};

  initial begin
    int lat, s0, unstable;
    logic [15:0] held_r;
    logic [3:0]  held_g;

    reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b1; hang = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_div_start", div_start, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_div_ab", {div_a, div_b}, 0);
    check("rst_out", {out_result, out_tag, out_overflow, out_timeout}, 0);
    @(posedge clk); #1 reset = 1'b1;

    // Single divide
    got_q.delete();
    s0 = starts;
    push_lat(16'h0400, 16'h0200, 4'd3, lat);
    check("t1_latency", lat, 25);
    check("t1_result", out_result, 16'h0002);
    check("t1_tag", out_tag, 3);
    check("t1_ovf", out_overflow, 0);
    wait_idle("t1_idle");
    check("t1_start_len", last_run, L);
    check("t1_starts", starts - s0, 1);

    // Back-to-back fill
    got_q.delete();
    min_gap = 1000;
    s0 = starts;
    for (int i = 0; i < 5; i++) push(va[i], vb[i], 4'(i));
    @(negedge clk);
    check("t2_full", in_ready, 0);
    push(va[5], vb[5], 4'd5);
    wait_results(6);
    for (int i = 0; i < 6; i++) check_res($sformatf("t2_%0d", i), i, exp_r[i], exp_o[i], 4'(i));
    wait_idle("t2_idle");
    check("t2_gap_ge2", min_gap >= 2, 1);
    check("t2_starts", starts - s0, 6);

    // Divide-by-zero
    got_q.delete();
    s0 = starts;
    push_lat(16'h8100, 16'h0000, 4'd6, lat);
    check("t3a_latency", lat, 2);
    check("t3a_result", out_result, 16'h8000);
    check("t3a_ovf", out_overflow, 1);
    check("t3a_tag", out_tag, 6);
    wait_idle("t3a_idle");
    push_lat(16'h0100, 16'h0000, 4'd7, lat);
    check("t3b_latency", lat, 2);
    check("t3b_result", out_result, 16'h7FFF);
    check("t3b_ovf", out_overflow, 1);
    check("t3b_tmo", out_timeout, 0);
    wait_idle("t3b_idle");
    check("t3_no_start", starts - s0, 0);

    // Output backpressure
    got_q.delete();
    out_ready = 1'b0;
    push(16'd1000, 16'd10, 4'd8);
    push(16'd81, 16'd3, 4'd9);
    push(16'h0400, 16'h0040, 4'd10);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check("t4_valid", out_valid, 1);
    check("t4_first_res", out_result, 16'd100);
    check("t4_first_tag", out_tag, 8);
    held_r = out_result;
    held_g = out_tag;
    s0 = starts;
    unstable = 0;
    repeat (50) begin
      @(negedge clk);
      if (!out_valid || out_result !== held_r || out_tag !== held_g) unstable++;
    end
    check("t4_stable", unstable, 0);
    check("t4_no_restart", starts - s0, 0);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_results(3);
    check_res("t4_0", 0, 16'd100, 1'b0, 4'd8);
    check_res("t4_1", 1, 16'd27, 1'b0, 4'd9);
    check_res("t4_2", 2, 16'd16, 1'b0, 4'd10);
    wait_idle("t4_idle");

    // Watchdog
    got_q.delete();
    hang = 1'b1;
    push_lat(16'h0100, 16'h0002, 4'd11, lat);
    check("t5_latency", lat, 66);
    check("t5_result", out_result, 0);
    check("t5_ovf", out_overflow, 1);
    check("t5_tmo", out_timeout, 1);
    check("t5_tag", out_tag, 11);
    wait_idle("t5_idle");
    check("t5_start_len", last_run, 64);
    hang = 1'b0;
    push_lat(16'd300, 16'd4, 4'd12, lat);
    check("t5b_result", out_result, 16'd75);
    check("t5b_tmo", out_timeout, 0);
    check("t5b_tag", out_tag, 12);
    wait_idle("t5b_idle");

    // Reset mid-operation
    push(16'h0400, 16'h0002, 4'd13);
    push(16'h0500, 16'h0002, 4'd14);
    push(16'h0600, 16'h0002, 4'd15);
    lat = 0;
    @(negedge clk);
    while (!div_start && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    repeat (10) @(negedge clk);
    check("t6_in_issue", div_start, 1);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_start", div_start, 0);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ready", in_ready, 1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    got_q.delete();
    s0 = starts;
    repeat (100) @(negedge clk);
    check("t6_no_stale", got_q.size(), 0);
    check("t6_no_start", starts - s0, 0);
    check("t6_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
